// File: rtl/fft_peak_tracker.sv
// fft_peak_tracker: per-frame |X|^2 top-NUM_PEAKS tracker over a bin window on the FFT output stream.
// Optional in-window energy sum when FFT_PEAK_ENERGY_EN is defined.
module fft_peak_tracker #(
  parameter int DATA_WIDTH = 24,
  parameter int FFT_SIZE   = 256,
  parameter int NUM_PEAKS  = 4,
  parameter int BIN_W      = $clog2(FFT_SIZE),
  parameter int MAG_W      = 2*DATA_WIDTH,
  parameter int CNT_W      = $clog2(NUM_PEAKS+1)
) (
  input  logic                          clk,
  input  logic                          resetb,
  input  logic signed [DATA_WIDTH-1:0]  bin_real_i,
  input  logic signed [DATA_WIDTH-1:0]  bin_imag_i,
  input  logic                          bin_valid_i,
  output logic                          bin_ready_o,
  input  logic [BIN_W-1:0]              lo_bin_i,
  input  logic [BIN_W-1:0]              hi_bin_i,
  input  logic                          clear_i,
  output logic [NUM_PEAKS*BIN_W-1:0]    peak_bin_o,
  output logic [NUM_PEAKS*MAG_W-1:0]    peak_mag_o,
  output logic [CNT_W-1:0]              peak_count_o,
  output logic                          result_valid_o,
  input  logic                          result_ready_i,
  output logic                          overrun_o,
  output logic [MAG_W+BIN_W-1:0]        frame_energy_o
);
  typedef enum logic [1:0] {ACCUM, DRAIN, PUBLISH} state_t;
  state_t state, state_nxt;
  logic [BIN_W-1:0] cnt, lo_r, hi_r, win_lo, win_hi;
  logic drain_cnt, accept, last, publish, ins;
  logic signed [MAG_W-1:0] re_x, im_x, sq_re, sq_im;
  logic [MAG_W-1:0] mag_c, s1_mag;
  logic [BIN_W-1:0] s1_idx;
  logic s1_vld, s1_in;
  logic [MAG_W-1:0] sm [NUM_PEAKS];
  logic [MAG_W-1:0] sm_n [NUM_PEAKS];
  logic [BIN_W-1:0] sb [NUM_PEAKS];
  logic [BIN_W-1:0] sb_n [NUM_PEAKS];
  logic [NUM_PEAKS-1:0] gt;
  logic [CNT_W-1:0] pc;
  assign accept  = bin_valid_i && bin_ready_o && !clear_i;
  assign last    = accept && cnt == BIN_W'(FFT_SIZE-1);
  assign publish = state == PUBLISH && !clear_i;
  always_comb begin
    state_nxt   = state;
    bin_ready_o = state == ACCUM;
    state_nxt   = clear_i ? ACCUM :
                  state == ACCUM ? (last ? DRAIN : ACCUM) :
                  state == DRAIN ? (drain_cnt ? PUBLISH : DRAIN) : ACCUM;
  end
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      state     <= ACCUM;
      drain_cnt <= 1'b0;
      cnt       <= '0;
      lo_r      <= '0;
      hi_r      <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN && !clear_i) ? ~drain_cnt : 1'b0;
      cnt       <= clear_i ? '0 : accept ? cnt + 1'b1 : cnt;
      if (accept && cnt == '0) begin
        lo_r <= lo_bin_i;
        hi_r <= hi_bin_i;
      end
    end
  // bin 0 compares against the live window inputs since that is the sampling cycle
  assign win_lo = cnt == '0 ? lo_bin_i : lo_r;
  assign win_hi = cnt == '0 ? hi_bin_i : hi_r;
  assign re_x   = MAG_W'(bin_real_i);
  assign im_x   = MAG_W'(bin_imag_i);
  assign sq_re  = re_x * re_x;
  assign sq_im  = im_x * im_x;
  assign mag_c  = $unsigned(sq_re) + $unsigned(sq_im);
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      s1_vld <= 1'b0;
      s1_in  <= 1'b0;
      s1_mag <= '0;
      s1_idx <= '0;
    end else begin
      s1_vld <= accept;
      s1_in  <= cnt >= win_lo && cnt <= win_hi;
      s1_mag <= mag_c;
      s1_idx <= cnt;
    end
  assign ins = s1_vld && s1_in && s1_mag != '0;
  // slots stay sorted, so gt is a thermometer code marking where the new bin lands
  for (genvar i = 0; i < NUM_PEAKS; i++) begin : g_slot
    assign gt[i] = ins && s1_mag > sm[i];
    if (i == 0) begin : g_top
      assign sm_n[i] = gt[i] ? s1_mag : sm[i];
      assign sb_n[i] = gt[i] ? s1_idx : sb[i];
    end else begin : g_rest
      assign sm_n[i] = gt[i] ? (gt[i-1] ? sm[i-1] : s1_mag) : sm[i];
      assign sb_n[i] = gt[i] ? (gt[i-1] ? sb[i-1] : s1_idx) : sb[i];
    end
  end
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      sm <= '{default: '0};
      sb <= '{default: '0};
    end else if (clear_i || publish) begin
      sm <= '{default: '0};
      sb <= '{default: '0};
    end else begin
      sm <= sm_n;
      sb <= sb_n;
    end
  always_comb begin
    pc = '0;
    for (int i = 0; i < NUM_PEAKS; i++) pc = pc + CNT_W'(sm[i] != '0);
  end
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      peak_bin_o     <= '0;
      peak_mag_o     <= '0;
      peak_count_o   <= '0;
      result_valid_o <= 1'b0;
      overrun_o      <= 1'b0;
    end else if (publish) begin
      for (int i = 0; i < NUM_PEAKS; i++) begin
        peak_bin_o[i*BIN_W +: BIN_W] <= sb[i];
        peak_mag_o[i*MAG_W +: MAG_W] <= sm[i];
      end
      peak_count_o   <= pc;
      result_valid_o <= 1'b1;
      if (result_valid_o && !result_ready_i) overrun_o <= 1'b1;
    end else if (result_valid_o && result_ready_i) begin
      result_valid_o <= 1'b0;
    end
`ifdef FFT_PEAK_ENERGY_EN
  logic [MAG_W+BIN_W-1:0] acc;
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      acc            <= '0;
      frame_energy_o <= '0;
    end else begin
      acc <= (clear_i || publish) ? '0 : (s1_vld && s1_in) ? acc + (MAG_W+BIN_W)'(s1_mag) : acc;
      if (publish) frame_energy_o <= acc;
    end
`else
  assign frame_energy_o = '0;
`endif
endmodule

// File: tb/tb_fft_peak_tracker.sv
// tb_fft_peak_tracker: randomized frames checked against a top-N selection model.
module tb_fft_peak_tracker;
  localparam int DW = 24, N = 16, NP = 2, BW = 4, MW = 48, CW = 2, EW = 52;
  logic clk = 0, resetb = 0;
  always #5 clk = ~clk;
  logic signed [DW-1:0] bin_real_i = '0, bin_imag_i = '0;
  logic bin_valid_i = 0, bin_ready_o, clear_i = 0, result_valid_o, result_ready_i = 0, overrun_o;
  logic [BW-1:0] lo_bin_i = '0, hi_bin_i = '0;
  logic [NP*BW-1:0] peak_bin_o;
  logic [NP*MW-1:0] peak_mag_o;
  logic [CW-1:0] peak_count_o;
  logic [EW-1:0] frame_energy_o;
  fft_peak_tracker #(.DATA_WIDTH(DW), .FFT_SIZE(N), .NUM_PEAKS(NP)) dut (
    .clk(clk), .resetb(resetb), .bin_real_i(bin_real_i), .bin_imag_i(bin_imag_i),
    .bin_valid_i(bin_valid_i), .bin_ready_o(bin_ready_o), .lo_bin_i(lo_bin_i), .hi_bin_i(hi_bin_i),
    .clear_i(clear_i), .peak_bin_o(peak_bin_o), .peak_mag_o(peak_mag_o), .peak_count_o(peak_count_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .overrun_o(overrun_o),
    .frame_energy_o(frame_energy_o));
  int checks = 0, errors = 0;
  int fr_re [N], fr_im [N];
  int e_bin [NP];
  longint e_mag [NP];
  int e_cnt;
  longint e_en;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic void model(input int lo, input int hi);
    longint m [N];
    bit used [N];
    int best;
    e_en = 0;
    e_cnt = 0;
    for (int b = 0; b < N; b++) begin
      m[b] = longint'(fr_re[b]) * fr_re[b] + longint'(fr_im[b]) * fr_im[b];
      if (b >= lo && b <= hi) e_en += m[b];
      used[b] = !(b >= lo && b <= hi && m[b] > 0);
    end
    for (int s = 0; s < NP; s++) begin
      e_bin[s] = 0;
      e_mag[s] = 0;
      best = -1;
      for (int b = 0; b < N; b++) if (!used[b] && (best < 0 || m[b] > m[best])) best = b;
      if (best >= 0) begin
        used[best] = 1;
        e_bin[s] = best;
        e_mag[s] = m[best];
        e_cnt++;
      end
    end
  endfunction
  task automatic zero_frame();
    for (int b = 0; b < N; b++) begin
      fr_re[b] = 0;
      fr_im[b] = 0;
    end
  endtask
  task automatic rand_frame(input int max);
    for (int b = 0; b < N; b++) begin
      fr_re[b] = $urandom_range(0, 1) ? $urandom_range(0, 2*max) - max : 0;
      fr_im[b] = $urandom_range(0, 1) ? $urandom_range(0, 2*max) - max : 0;
    end
  endtask
  task automatic send_frame(input int lo, input int hi, input int stop_at);
    int lat;
    for (int b = 0; b < N; b++) begin
      while ($urandom_range(0, 3) == 0) begin
        bin_valid_i = 0;
        lo_bin_i = 4'($urandom);
        hi_bin_i = 4'($urandom);
        @(posedge clk); #1;
      end
      bin_valid_i = 1;
      bin_real_i = DW'(fr_re[b]);
      bin_imag_i = DW'(fr_im[b]);
      lo_bin_i = b == 0 ? 4'(lo) : 4'($urandom);
      hi_bin_i = b == 0 ? 4'(hi) : 4'($urandom);
      clear_i = b == stop_at;
      @(posedge clk); #1;
      if (b == stop_at) begin
        bin_valid_i = 0;
        clear_i = 0;
        return;
      end
    end
    bin_valid_i = 0;
    lat = 0;
    while (!bin_ready_o && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ready_low_cycles", 64'(lat), 64'd3);
    check("valid_at_publish", 64'(result_valid_o), 64'd1);
  endtask
  task automatic check_result(input string tag);
    for (int s = 0; s < NP; s++) begin
      check({tag, "_bin"}, 64'(peak_bin_o[s*BW +: BW]), 64'(e_bin[s]));
      check({tag, "_mag"}, 64'(peak_mag_o[s*MW +: MW]), 64'(e_mag[s]));
    end
    check({tag, "_count"}, 64'(peak_count_o), 64'(e_cnt));
`ifdef FFT_PEAK_ENERGY_EN
    check({tag, "_energy"}, 64'(frame_energy_o), 64'(e_en));
`else
    check({tag, "_energy"}, 64'(frame_energy_o), 64'd0);
`endif
    result_ready_i = 1;
    @(posedge clk); #1;
    result_ready_i = 0;
    check({tag, "_drop"}, 64'(result_valid_o), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    int lo, hi;
    #12;
    check("rst_ready", 64'(bin_ready_o), 64'd1);
    check("rst_valid", 64'(result_valid_o), 64'd0);
    check("rst_peaks", 64'({peak_bin_o, peak_count_o}), 64'd0);
    @(posedge clk); #1;
    resetb = 1;
    zero_frame();
    fr_re[3] = 100;
    fr_im[9] = -200;
    send_frame(0, 15, -1);
    model(0, 15);
    check("f1_top_const", 64'(peak_mag_o[MW-1:0]), 64'd40000);
    check_result("f1");
    send_frame(4, 15, -1);
    model(4, 15);
    check_result("win4");
    send_frame(10, 5, -1);
    model(10, 5);
    check_result("inverted");
    zero_frame();
    fr_re[2] = 50; fr_im[2] = 50;
    fr_re[5] = 50; fr_im[5] = 50;
    send_frame(0, 15, -1);
    model(0, 15);
    check("tie_first", 64'(peak_bin_o[BW-1:0]), 64'd2);
    check_result("tie");
    rand_frame(1000);
    fr_re[6] = -(1 << 23);
    fr_im[6] = -(1 << 23);
    send_frame(0, 15, -1);
    model(0, 15);
    check("fullscale", 64'(peak_mag_o[MW-1:0]), 64'h8000_0000_0000);
    check_result("full");
    for (int k = 0; k < 10; k++) begin
      rand_frame((1 << 23) - 1);
      lo = $urandom_range(0, 15);
      hi = $urandom_range(0, 15);
      send_frame(lo, hi, -1);
      model(lo, hi);
      check_result($sformatf("rnd%0d", k));
    end
    check("no_overrun_yet", 64'(overrun_o), 64'd0);
    rand_frame(5000);
    send_frame(0, 15, -1);
    rand_frame(5000);
    send_frame(0, 15, -1);
    model(0, 15);
    check("overrun_set", 64'(overrun_o), 64'd1);
    check_result("ovr");
    check("overrun_sticky", 64'(overrun_o), 64'd1);
    rand_frame(100000);
    send_frame(0, 15, 7);
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_result", 64'(result_valid_o), 64'd0);
    zero_frame();
    fr_re[1] = 1;
    fr_im[1] = 1;
    send_frame(0, 15, -1);
    model(0, 15);
    check_result("post_clear");
    zero_frame();
    fr_re[4] = 7;
    send_frame(0, 15, -1);
    bin_valid_i = 1;
    repeat (5) @(posedge clk);
    #1;
    resetb = 0;
    bin_valid_i = 0;
    #2;
    check("mid_rst_ready", 64'(bin_ready_o), 64'd1);
    check("mid_rst_valid", 64'(result_valid_o), 64'd0);
    check("mid_rst_ovr", 64'(overrun_o), 64'd0);
    check("mid_rst_bins", 64'(peak_bin_o), 64'd0);
    check("mid_rst_mags", 64'(peak_mag_o[MW-1:0]), 64'd0);
    check("mid_rst_energy", 64'(frame_energy_o), 64'd0);
    @(posedge clk); #1;
    resetb = 1;
    rand_frame(3000);
    send_frame(2, 13, -1);
    model(2, 13);
    check_result("after_rst");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_peak_tracker.md
Name: fft_peak_tracker

Overview:
Streaming consumer that sits directly on the fft_256 output handshake. For every FFT frame it computes magnitude-squared per bin and tracks the NUM_PEAKS largest bins inside a programmable bin window, then publishes a sorted peak list once per frame. It replaces single-peak LED logic and feeds the LED and display paths.

Parameters:
DATA_WIDTH, 24, signed width of bin real/imag inputs
FFT_SIZE, 256, bins per frame (power of 2, >= 8)
NUM_PEAKS, 4, number of tracked peaks (1..8)
BIN_W, $clog2(FFT_SIZE), bin index width (derived)
MAG_W, 2*DATA_WIDTH, unsigned magnitude-squared width (derived)

Ports:
clk  in  1  clock
resetb  in  1  reset
bin_real_i  in  DATA_WIDTH  signed bin real part
bin_imag_i  in  DATA_WIDTH  signed bin imaginary part
bin_valid_i  in  1  bin valid
bin_ready_o  out  1  tracker accepts bin
lo_bin_i  in  BIN_W  first bin of search window, inclusive
hi_bin_i  in  BIN_W  last bin of search window, inclusive
clear_i  in  1  synchronous frame abort
peak_bin_o  out  NUM_PEAKS*BIN_W  peak bin indices, slot 0 in LSBs = largest
peak_mag_o  out  NUM_PEAKS*MAG_W  peak magnitudes, same slot order
peak_count_o  out  $clog2(NUM_PEAKS+1)  number of populated slots
result_valid_o  out  1  result available
result_ready_i  in  1  consumer accepts result
overrun_o  out  1  sticky: unread result overwritten
frame_energy_o  out  MAG_W+BIN_W  in-window energy (optional feature)

Behaviour:
- Reset is asynchronous and active-low on resetb, clocked by clk. All outputs reset to 0 except bin_ready_o, which resets to 1. Internal bin counter and tracker slots are cleared.
- FSM states: ACCUM, DRAIN, PUBLISH.
- ACCUM:
  - bin_ready_o = 1. A bin is accepted when bin_valid_i && bin_ready_o.
  - The bin counter increments on each accept. It starts at 0 and the accepted index is the counter value.
  - lo_bin_i and hi_bin_i are sampled when bin 0 is accepted and held for the whole frame.
- Pipeline:
  - Stage 1 registers mag = re*re + im*im, unsigned MAG_W, computed exactly with no saturation, plus index and an in-window flag.
  - Stage 2 performs sorted insertion.
- Insertion rules:
  - Only in-window bins with mag > 0 are inserted.
  - A new bin displaces a slot only if strictly greater, so on ties the earlier bin keeps the higher rank.
  - Lower slots shift down and the smallest is dropped.
  - Empty slots read bin 0, mag 0.
- Frame end:
  - Accepting bin FFT_SIZE-1 moves the FSM to DRAIN. bin_ready_o drops the next cycle and the counter wraps to 0.
  - DRAIN lasts 2 cycles, then PUBLISH lasts 1 cycle.
  - In PUBLISH, the slots are copied to the output registers and result_valid_o rises. This is 3 cycles after the last-bin accept edge.
  - The tracker is then cleared, and the FSM returns to ACCUM with bin_ready_o = 1.
- Result handshake:
  - result_valid_o holds until result_valid_o && result_ready_i; the output registers are stable while valid.
  - If PUBLISH occurs while result_valid_o is already set, the new result overwrites the old one, result_valid_o stays 1 and overrun_o sets.
  - overrun_o clears only on reset.
  - When the old result's handshake and PUBLISH happen in the same cycle, the new result loads, valid stays 1, and there is no overrun.
- Window edge cases:
  - lo > hi: no bin qualifies; the result publishes with peak_count_o = 0.
  - hi ≥ FFT_SIZE cannot occur because of the BIN_W width.
- clear_i:
  - In any state, the bin counter returns to 0, the tracker and pipeline are flushed, and the FSM goes to ACCUM next cycle. The partial frame produces no result.
  - Output result registers and overrun_o are untouched.
  - clear_i has priority over a simultaneous accept.

Optional Feature:
FFT_PEAK_ENERGY_EN:
- Defined: frame_energy_o publishes, alongside the peaks, the sum of mag over all in-window bins, including zero-magnitude bins (no effect). The accumulator has width MAG_W+BIN_W, cannot overflow, and clears with the tracker.
- Undefined: frame_energy_o is tied to 0 and no accumulator is built.

Test Plan:
- FFT_SIZE=16, NUM_PEAKS=2, window 0..15; bin 3 = (100,0), bin 9 = (0,-200), others 0, result_ready_i=1 -> peaks {9:40000, 3:10000}, count 2, result_valid_o high 3 cycles after bin-15 accept; bin_ready_o low exactly 3 cycles.
- Same frame, window 4..15 -> peaks {9:40000, empty}, count 1; window lo=10, hi=5 -> count 0, all slots 0.
- Tie: bins 2 and 5 both (50,50), NUM_PEAKS=1 -> bin 2, mag 5000.
- result_ready_i=0 over two frames -> second frame's results shown, overrun_o=1, persists after a later accept.
- clear_i at bin 7, then a full frame containing only bin 1=(1,1) -> single result {1:2}, no result from the aborted frame; resetb low mid-frame -> all outputs 0, bin_ready_o=1.
- Full-scale bin (-2^23,-2^23), DATA_WIDTH=24 -> mag 2^47 exact; with FFT_PEAK_ENERGY_EN, bins 3/9 frame -> frame_energy_o=50000.
